// File: rtl/xc_aessub_pkg.sv
// Shared AES definitions for the xc_aes* instruction units.
//   - S-box affine constants and the GF(2^8) reduction polynomial
//   - FSM state encodings for the iterative SubBytes unit
//   - GF(2^8) helper functions: multiply, invert, forward/inverse affine
// Config macro used by the consumers of this package: XC_AESSUB_PARALLEL_EN
package xc_aessub_pkg;

  localparam logic [7:0] AES_AFFINE_FWD = 8'h63;
  localparam logic [7:0] AES_AFFINE_INV = 8'h05;
  localparam logic [8:0] AES_POLY       = 9'h11b;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Shift-and-add multiply; each doubling is reduced by the low byte of the
  // polynomial since bit 8 falls off the top of the byte.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (Fermat), using the addition chain
  // 2,3,12,15,240,252,254. a=0 naturally maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ AES_AFFINE_FWD;
  endfunction

  // rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  function automatic logic [7:0] aff_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ AES_AFFINE_INV;
  endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combinational AES S-box, forward and inverse.
// Ports:
//   a   in  8  input byte
//   enc in  1  1 = forward S-box, 0 = inverse S-box
//   s   out 8  substituted byte
// One field inverter is shared by both directions: the forward path applies
// the affine map after inversion, the inverse path applies the inverse affine
// map before inversion.
module xc_aes_sbox
  import xc_aessub_pkg::*;
(
  input  logic [7:0] a,
  input  logic       enc,
  output logic [7:0] s
);

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  assign inv_in  = enc ? a : aff_inv(a);
  assign inv_out = gf_inv(inv_in);
  assign s       = enc ? aff_fwd(inv_out) : inv_out;

endmodule

// File: rtl/xc_aessub.sv
// AES SubBytes instruction unit (xc.aessub.enc / xc.aessub.dec).
// Gathers one ShiftRows-permuted column from rs1/rs2 and substitutes each byte.
// Ports:
//   clock  in  1   clock, rising edge
//   reset  in  1   synchronous, active-low reset
//   valid  in  1   request outstanding
//   rs1    in  32  source register 1
//   rs2    in  32  source register 2
//   enc    in  1   1 = forward S-box, 0 = inverse S-box
//   ready  out 1   result valid this cycle (one-cycle pulse, registered)
//   result out 32  {S(rs2[31:24]), S(rs1[23:16]), S(rs2[15:8]), S(rs1[7:0])}
// Config: define XC_AESSUB_PARALLEL_EN for four S-boxes and single-cycle
// latency; otherwise one shared S-box processes a byte per cycle.
module xc_aessub
  import xc_aessub_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ctr_q, ctr_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic [31:0] col_word;

  assign col_word = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};

`ifdef XC_AESSUB_PARALLEL_EN
  logic [31:0] sub_word;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    xc_aes_sbox u_sbox (
      .a   (col_word[8*g +: 8]),
      .enc (enc),
      .s   (sub_word[8*g +: 8])
    );
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = 2'd0;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          result_d = sub_word;
          state_d  = ST_DONE;
          ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`else
  logic [7:0] sel_byte;
  logic [7:0] sub_byte;

  // ctr is 0 in IDLE, so the same mux serves the first byte and the BUSY bytes.
  assign sel_byte = col_word[{ctr_q, 3'b000} +: 8];

  xc_aes_sbox u_sbox (
    .a   (sel_byte),
    .enc (enc),
    .s   (sub_byte)
  );

  // ready is raised on entry to DONE rather than decoded from valid, so there
  // is no combinational input-to-ready path; the requester keeps valid high
  // until it sees ready, so the two agree.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          result_d[7:0] = sub_byte;
          ctr_d         = 2'd1;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (valid) begin
          result_d[{ctr_q, 3'b000} +: 8] = sub_byte;
          ctr_d = ctr_q + 2'd1;
          if (ctr_q == 2'd3) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end
        end else begin
          // Abort: the partially written result stays but is never flagged ready.
          ctr_d   = 2'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ctr_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctr_q    <= 2'd0;
      result_q <= 32'h0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule
